// File: rtl/audio_sample_packetizer.sv
// Collects up to four stereo samples per request and emits one audio sample packet.
// Optional macro AUDIO_CHANNEL_STATUS_EN drives the C bits from the channel status block.
module audio_sample_packetizer #(
    parameter int         BIT_WIDTH      = 16,
    parameter logic [3:0] CS_SAMPLE_FREQ = 4'b0010,
    parameter logic [3:0] CS_WORD_LENGTH = 4'b0010
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    input  logic                 sample_available,
    input  logic [BIT_WIDTH-1:0] audio_sample [2],
    output logic                 sample_pop,
    input  logic                 packet_request,
    output logic [23:0]          header,
    output logic [55:0]          sub [4],
    output logic                 packet_valid
);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  frame_q, frame_d;
    logic [55:0] slot_q [4];
    logic [55:0] slot_d [4];
    logic [3:0]  b_q, b_d;
    logic [23:0] header_q, header_d;
    logic [55:0] sub_q [4];
    logic [55:0] sub_d [4];
    logic [3:0]  present;
    logic        c_bit;

    function automatic logic cs_bit(input logic [7:0] n);
        if (n >= 8'd24 && n <= 8'd27) return CS_SAMPLE_FREQ[n[1:0]];
        if (n >= 8'd32 && n <= 8'd35) return CS_WORD_LENGTH[n[1:0]];
        return 1'b0;
    endfunction

    // Subpacket: MSB-aligned samples, V=U=0, P makes each subframe even.
    function automatic logic [55:0] pack(input logic [BIT_WIDTH-1:0] l,
                                         input logic [BIT_WIDTH-1:0] r,
                                         input logic c);
        logic [23:0] al;
        logic [23:0] ar;
        al = 24'(l) << (24 - BIT_WIDTH);
        ar = 24'(r) << (24 - BIT_WIDTH);
        return {^{ar, c}, c, 2'b00, ^{al, c}, c, 2'b00, ar, al};
    endfunction

`ifdef AUDIO_CHANNEL_STATUS_EN
    assign c_bit = cs_bit(frame_q);
`else
    assign c_bit = 1'b0;
`endif

    always_comb begin
        present = 4'b0000;
        for (int i = 0; i < 4; i++) present[i] = (3'(i) < count_q);
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        frame_d    = frame_q;
        slot_d     = slot_q;
        b_d        = b_q;
        header_d   = header_q;
        sub_d      = sub_q;
        sample_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (packet_request) begin
                    state_d = COLLECT;
                    count_d = 3'd0;
                end
            end
            COLLECT: begin
                if (sample_available && count_q < 3'd4) begin
                    sample_pop             = 1'b1;
                    slot_d[count_q[1:0]]   = pack(audio_sample[0], audio_sample[1], c_bit);
                    b_d[count_q[1:0]]      = (frame_q == 8'd0);
                    count_d                = count_q + 3'd1;
                    frame_d                = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
                end else if (count_q != 3'd0) begin
                    state_d  = EMIT;
                    header_d = {b_q & present, 4'b0000, 4'b0000, present, 8'h02};
                    for (int i = 0; i < 4; i++)
                        sub_d[i] = present[i] ? slot_q[i] : 56'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 3'd0;
            frame_q  <= 8'd0;
            b_q      <= 4'b0000;
            header_q <= 24'd0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= 56'd0;
                sub_q[i]  <= 56'd0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            frame_q  <= frame_d;
            b_q      <= b_d;
            header_q <= header_d;
            slot_q   <= slot_d;
            sub_q    <= sub_d;
        end
    end

    assign header       = header_q;
    assign sub          = sub_q;
    assign packet_valid = (state_q == EMIT);

endmodule

// File: tb/tb_audio_sample_packetizer.sv
// Directed bench for audio_sample_packetizer: one task per scenario.
module tb_audio_sample_packetizer;

    logic        clk_pixel = 1'b0;
    logic        reset = 1'b1;
    logic        sample_available = 1'b0;
    logic        packet_request = 1'b0;
    logic [15:0] audio_sample [2];
    logic        sample_pop;
    logic [23:0] header;
    logic [55:0] sub [4];
    logic        packet_valid;

    int          checks = 0;
    int          errors = 0;
    int          tb_frame = 0;
    int          sidx = 0;
    int          pops, nvalid, vcyc;
    logic [23:0] cap_hdr;
    logic [55:0] cap_sub [4];
    int          slot_frame [4];

    always #5 clk_pixel = ~clk_pixel;

    audio_sample_packetizer dut (
        .clk_pixel(clk_pixel),
        .reset(reset),
        .sample_available(sample_available),
        .audio_sample(audio_sample),
        .sample_pop(sample_pop),
        .packet_request(packet_request),
        .header(header),
        .sub(sub),
        .packet_valid(packet_valid)
    );

    function automatic logic exp_c(input int f);
`ifdef AUDIO_CHANNEL_STATUS_EN
        return (f == 25 || f == 33);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive_sample();
        audio_sample[0] = 16'h1234 + 16'(sidx);
        audio_sample[1] = 16'h8001 + 16'(sidx);
    endtask

    task automatic run_packet(input int navail);
        int   rem;
        logic pop_now;
        rem = navail;
        pops = 0;
        nvalid = 0;
        vcyc = -1;
        sidx = 0;
        drive_sample();
        sample_available = (rem > 0);
        packet_request = 1'b1;
        @(posedge clk_pixel);
        #1 packet_request = 1'b0;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (packet_valid) begin
                nvalid++;
                vcyc = c;
                cap_hdr = header;
                cap_sub = sub;
            end
            pop_now = sample_pop;
            if (pop_now && pops < 4) slot_frame[pops] = tb_frame;
            @(posedge clk_pixel);
            #1;
            if (pop_now) begin
                pops++;
                rem--;
                sidx++;
                tb_frame = (tb_frame + 1) % 192;
                drive_sample();
                sample_available = (rem > 0);
            end
            #1;
        end
    endtask

    task automatic test_reset();
        sample_available = 1'b1;
        drive_sample();
        packet_request = 1'b1;
        repeat (2) @(posedge clk_pixel);
        #1;
        checks++;
        if (sample_pop !== 1'b0) begin
            errors++;
            $display("FAIL reset_pop got %b want 0", sample_pop);
        end
        checks++;
        if (packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", packet_valid);
        end
        checks++;
        if (header !== 24'd0) begin
            errors++;
            $display("FAIL reset_header got %h want 000000", header);
        end
        checks++;
        if (sub[0] !== 56'd0 || sub[3] !== 56'd0) begin
            errors++;
            $display("FAIL reset_sub got %h/%h want 0", sub[0], sub[3]);
        end
        packet_request = 1'b0;
        sample_available = 1'b0;
        @(posedge clk_pixel);
        #1 reset = 1'b0;
        tb_frame = 0;
    endtask

    task automatic test_full_packet();
        run_packet(4);
        checks++;
        if (pops !== 4) begin
            errors++;
            $display("FAIL full_pops got %0d want 4", pops);
        end
        checks++;
        if (nvalid !== 1 || vcyc !== 5) begin
            errors++;
            $display("FAIL full_valid got n=%0d cyc=%0d want n=1 cyc=5", nvalid, vcyc);
        end
        checks++;
        if (cap_hdr !== 24'h100F02) begin
            errors++;
            $display("FAIL full_header got %h want 100f02", cap_hdr);
        end
        checks++;
        if (cap_sub[0] !== 56'h08800100123400) begin
            errors++;
            $display("FAIL full_sub0 got %h want 08800100123400", cap_sub[0]);
        end
        checks++;
        if (cap_sub[1] !== 56'h00800200123500) begin
            errors++;
            $display("FAIL full_sub1 got %h want 00800200123500", cap_sub[1]);
        end
        checks++;
        if (cap_sub[2] !== 56'h80800300123600) begin
            errors++;
            $display("FAIL full_sub2 got %h want 80800300123600", cap_sub[2]);
        end
        checks++;
        if (header !== 24'h100F02 || packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got %h/%b want 100f02/0", header, packet_valid);
        end
    endtask

    task automatic test_partial();
        run_packet(2);
        checks++;
        if (pops !== 2 || nvalid !== 1) begin
            errors++;
            $display("FAIL part_count got pops=%0d n=%0d want 2/1", pops, nvalid);
        end
        checks++;
        if (cap_hdr !== 24'h000302) begin
            errors++;
            $display("FAIL part_header got %h want 000302", cap_hdr);
        end
        checks++;
        if (cap_sub[0] !== 56'h08800100123400) begin
            errors++;
            $display("FAIL part_sub0 got %h want 08800100123400", cap_sub[0]);
        end
        checks++;
        if (cap_sub[2] !== 56'd0 || cap_sub[3] !== 56'd0) begin
            errors++;
            $display("FAIL part_empty got %h/%h want 0", cap_sub[2], cap_sub[3]);
        end
    endtask

    task automatic test_empty();
        run_packet(0);
        checks++;
        if (pops !== 0 || nvalid !== 0) begin
            errors++;
            $display("FAIL empty_count got pops=%0d n=%0d want 0/0", pops, nvalid);
        end
        checks++;
        if (header !== 24'h000302) begin
            errors++;
            $display("FAIL empty_hold got %h want 000302", header);
        end
    endtask

    task automatic test_reset_mid();
        int nv;
        sidx = 0;
        drive_sample();
        sample_available = 1'b1;
        packet_request = 1'b1;
        @(posedge clk_pixel);
        #1 packet_request = 1'b0;
        @(posedge clk_pixel);
        @(posedge clk_pixel);
        #1;
        checks++;
        if (sample_pop !== 1'b1) begin
            errors++;
            $display("FAIL mid_pop got %b want 1", sample_pop);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (sample_pop !== 1'b0 || packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_ctrl got pop=%b v=%b want 0/0", sample_pop, packet_valid);
        end
        checks++;
        if (header !== 24'd0 || sub[0] !== 56'd0) begin
            errors++;
            $display("FAIL mid_out got %h/%h want 0", header, sub[0]);
        end
        sample_available = 1'b0;
        @(posedge clk_pixel);
        #1 reset = 1'b0;
        tb_frame = 0;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_pixel);
            #1 if (packet_valid) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL mid_novalid got %0d want 0", nv);
        end
        run_packet(4);
        checks++;
        if (cap_hdr !== 24'h100F02) begin
            errors++;
            $display("FAIL mid_restart got %h want 100f02", cap_hdr);
        end
    endtask

    task automatic test_stream();
        int         btotal;
        logic [3:0] bexp;
        logic [7:0] cexp, cgot;
        logic [7:0] par;
        reset = 1'b1;
        #1;
        @(posedge clk_pixel);
        #1 reset = 1'b0;
        tb_frame = 0;
        btotal = 0;
        for (int p = 0; p < 50; p++) begin
            run_packet(4);
            checks++;
            if (pops !== 4 || nvalid !== 1) begin
                errors++;
                $display("FAIL stream_count pkt %0d got pops=%0d n=%0d want 4/1", p, pops, nvalid);
            end
            bexp = 4'b0000;
            cexp = 8'd0;
            cgot = 8'd0;
            par = 8'd0;
            for (int i = 0; i < 4; i++) begin
                bexp[i] = (slot_frame[i] == 0);
                cexp[2*i] = exp_c(slot_frame[i]);
                cexp[2*i+1] = exp_c(slot_frame[i]);
                cgot[2*i] = cap_sub[i][50];
                cgot[2*i+1] = cap_sub[i][54];
                par[2*i] = ^{cap_sub[i][23:0], cap_sub[i][51:48]};
                par[2*i+1] = ^{cap_sub[i][47:24], cap_sub[i][55:52]};
            end
            btotal += $countones(cap_hdr[23:20]);
            checks++;
            if (cap_hdr[23:20] !== bexp) begin
                errors++;
                $display("FAIL stream_b pkt %0d got %b want %b", p, cap_hdr[23:20], bexp);
            end
            checks++;
            if (par !== 8'd0) begin
                errors++;
                $display("FAIL stream_parity pkt %0d got %b want 0", p, par);
            end
            checks++;
            if (cgot !== cexp) begin
                errors++;
                $display("FAIL stream_c pkt %0d got %b want %b", p, cgot, cexp);
            end
        end
        checks++;
        if (btotal !== 2) begin
            errors++;
            $display("FAIL stream_btotal got %0d want 2", btotal);
        end
    endtask

    initial begin
        audio_sample[0] = 16'd0;
        audio_sample[1] = 16'd0;
        test_reset();
        test_full_packet();
        test_partial();
        test_empty();
        test_reset_mid();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
